// File: rtl/kernel_cc_start_fifo_mc.sv
// Multi-channel shift-register FIFO with first-word-fall-through output and
// registered empty/full/almost-full flags.
// Ports: clk, reset (sync, active-high); if_write_ce/if_write/if_din and
// if_full_n/if_almost_full_n on the write side; if_read_ce/if_read and
// if_empty_n/if_dout on the read side; if_count per-channel occupancy;
// err_overflow/err_underflow sticky error flags.
// Optional macro KERNEL_CC_START_FIFO_ERR_EN enables the error flags;
// without it the error ports are tied to 0.
module kernel_cc_start_fifo_mc #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 2,
  parameter int DEPTH      = 4,
  parameter int NUM_CH     = 2,
  parameter int AF_THRESH  = DEPTH - 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             if_write_ce,
  input  logic [NUM_CH-1:0]                if_write,
  input  logic [NUM_CH*DATA_WIDTH-1:0]     if_din,
  output logic [NUM_CH-1:0]                if_full_n,
  output logic [NUM_CH-1:0]                if_almost_full_n,
  input  logic                             if_read_ce,
  input  logic [NUM_CH-1:0]                if_read,
  output logic [NUM_CH-1:0]                if_empty_n,
  output logic [NUM_CH*DATA_WIDTH-1:0]     if_dout,
  output logic [NUM_CH*(ADDR_WIDTH+1)-1:0] if_count,
  output logic [NUM_CH-1:0]                err_overflow,
  output logic [NUM_CH-1:0]                err_underflow
);

  localparam int CW  = ADDR_WIDTH + 1;
  localparam int MSZ = 1 << ADDR_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);

  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_ch
      logic [DATA_WIDTH-1:0] mem [MSZ];
      logic [CW-1:0]         count   = '0;
      logic                  empty_n = 1'b0;
      logic                  full_n  = 1'b1;
      logic                  af_n    = 1'b1;
      logic [CW-1:0]         cnt_nxt;
      logic [ADDR_WIDTH-1:0] rd_idx;
      logic [DATA_WIDTH-1:0] din;
      logic                  wa;
      logic                  ra;

      assign din = if_din[c*DATA_WIDTH +: DATA_WIDTH];
      assign wa  = if_write[c] & if_write_ce & full_n;
      assign ra  = if_read[c] & if_read_ce & empty_n;

      always_comb begin
        cnt_nxt = count;
        unique case (1'b1)
          (wa & ~ra): cnt_nxt = count + 1'b1;
          (ra & ~wa): cnt_nxt = count - 1'b1;
          default:    cnt_nxt = count;
        endcase
      end

      // Oldest entry sits at index count-1; new data always enters at 0.
      always_comb begin
        rd_idx = '0;
        if (count != '0)
          rd_idx = ADDR_WIDTH'(count - 1'b1);
      end

      assign if_dout[c*DATA_WIDTH +: DATA_WIDTH] = mem[rd_idx];

      // Storage is never cleared; reset only blocks the shift.
      always_ff @(posedge clk) begin
        if (!reset && wa) begin
          for (int i = MSZ - 1; i > 0; i--)
            mem[i] <= mem[i-1];
          mem[0] <= din;
        end
      end

      // Flags are registered copies of the next count's decode.
      always_ff @(posedge clk) begin
        if (reset) begin
          count   <= '0;
          empty_n <= 1'b0;
          full_n  <= 1'b1;
          af_n    <= 1'b1;
        end else begin
          count   <= cnt_nxt;
          empty_n <= (cnt_nxt != '0);
          full_n  <= (cnt_nxt != DEPTH_C);
          af_n    <= (cnt_nxt < AF_C);
        end
      end

      assign if_empty_n[c]       = empty_n;
      assign if_full_n[c]        = full_n;
      assign if_almost_full_n[c] = af_n;
      assign if_count[c*CW +: CW] = count;

`ifdef KERNEL_CC_START_FIFO_ERR_EN
      logic ovf = 1'b0;
      logic udf = 1'b0;

      always_ff @(posedge clk) begin
        if (reset) begin
          ovf <= 1'b0;
          udf <= 1'b0;
        end else begin
          if (if_write[c] & if_write_ce & ~full_n)
            ovf <= 1'b1;
          if (if_read[c] & if_read_ce & ~empty_n)
            udf <= 1'b1;
        end
      end

      assign err_overflow[c]  = ovf;
      assign err_underflow[c] = udf;
`else
      assign err_overflow[c]  = 1'b0;
      assign err_underflow[c] = 1'b0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_kernel_cc_start_fifo_mc.sv
// Self-checking bench for kernel_cc_start_fifo_mc: queue model, per-cycle
// compare, directed scenarios then randomized traffic with resets.
module tb_kernel_cc_start_fifo_mc;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DP = 4;
  localparam int NC = 2;
  localparam int AF = 3;
  localparam int CW = AW + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_write_ce = 1'b1;
  logic [NC-1:0] if_write = '0;
  logic [NC*DW-1:0] if_din = '0;
  logic [NC-1:0] if_full_n;
  logic [NC-1:0] if_almost_full_n;
  logic          if_read_ce = 1'b1;
  logic [NC-1:0] if_read = '0;
  logic [NC-1:0] if_empty_n;
  logic [NC*DW-1:0] if_dout;
  logic [NC*CW-1:0] if_count;
  logic [NC-1:0] err_overflow;
  logic [NC-1:0] err_underflow;

  kernel_cc_start_fifo_mc #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP),
    .NUM_CH(NC), .AF_THRESH(AF)
  ) dut (
    .clk(clk), .reset(reset),
    .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din),
    .if_full_n(if_full_n), .if_almost_full_n(if_almost_full_n),
    .if_read_ce(if_read_ce), .if_read(if_read),
    .if_empty_n(if_empty_n), .if_dout(if_dout), .if_count(if_count),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] mq [NC][$];
  bit m_ovf [NC];
  bit m_udf [NC];

  task automatic chk(input string name, input int c,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s ch%0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask

  // Reference model: one queue per channel, updated on each rising edge.
  always @(posedge clk) begin
    for (int c = 0; c < NC; c++) begin
      if (reset) begin
        mq[c].delete();
        m_ovf[c] = 1'b0;
        m_udf[c] = 1'b0;
      end else begin
        bit wr, rd;
        int sz;
        sz = mq[c].size();
        wr = if_write[c] && if_write_ce;
        rd = if_read[c] && if_read_ce;
        if (wr && sz == DP) m_ovf[c] = 1'b1;
        if (rd && sz == 0)  m_udf[c] = 1'b1;
        if (rd && sz > 0) void'(mq[c].pop_front());
        if (wr && sz < DP) mq[c].push_back(if_din[c*DW +: DW]);
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < NC; c++) begin
        int sz;
        sz = mq[c].size();
        chk("count", c, 32'(if_count[c*CW +: CW]), 32'(sz));
        chk("empty_n", c, 32'(if_empty_n[c]), 32'(sz != 0));
        chk("full_n", c, 32'(if_full_n[c]), 32'(sz != DP));
        chk("af_n", c, 32'(if_almost_full_n[c]), 32'(sz < AF));
        if (sz > 0)
          chk("dout", c, 32'(if_dout[c*DW +: DW]), 32'(mq[c][0]));
`ifdef KERNEL_CC_START_FIFO_ERR_EN
        chk("err_ovf", c, 32'(err_overflow[c]), 32'(m_ovf[c]));
        chk("err_udf", c, 32'(err_underflow[c]), 32'(m_udf[c]));
`else
        chk("err_ovf", c, 32'(err_overflow[c]), 32'd0);
        chk("err_udf", c, 32'(err_underflow[c]), 32'd0);
`endif
      end
    end
  end

  task automatic cyc(input logic rst, input logic wce,
                     input logic [NC-1:0] wr, input logic [NC*DW-1:0] din,
                     input logic rce, input logic [NC-1:0] rd);
    reset = rst;
    if_write_ce = wce;
    if_write = wr;
    if_din = din;
    if_read_ce = rce;
    if_read = rd;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] cnt(input int c);
    return 32'(if_count[c*CW +: CW]);
  endfunction

  function automatic logic [31:0] dout(input int c);
    return 32'(if_dout[c*DW +: DW]);
  endfunction

  initial begin
    logic [7:0] wv [4];
    wv[0] = 8'h11; wv[1] = 8'h22; wv[2] = 8'h33; wv[3] = 8'h44;

    cyc(1, 1, 2'b00, '0, 1, 2'b00);
    cyc(1, 1, 2'b00, '0, 1, 2'b00);
    chk_en = 1'b1;
    cyc(0, 1, 2'b00, '0, 1, 2'b00);
    chk("lit_rst_count", 0, cnt(0), 0);
    chk("lit_rst_full_n", 0, 32'(if_full_n), 32'h3);
    chk("lit_rst_empty_n", 0, 32'(if_empty_n), 32'h0);

    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 2'b01, {8'h00, wv[i]}, 1, 2'b00);
      chk("lit_fill_count", 0, cnt(0), 32'(i + 1));
      chk("lit_fill_ch1_empty_n", 1, 32'(if_empty_n[1]), 0);
      if (i == 2) chk("lit_af_n", 0, 32'(if_almost_full_n[0]), 0);
    end
    chk("lit_full_n", 0, 32'(if_full_n[0]), 0);

    cyc(0, 1, 2'b01, {8'h00, 8'h55}, 1, 2'b00);
    chk("lit_ovf_count", 0, cnt(0), 4);
`ifdef KERNEL_CC_START_FIFO_ERR_EN
    chk("lit_err_ovf", 0, 32'(err_overflow[0]), 1);
`endif

    for (int i = 0; i < 4; i++) begin
      chk("lit_drain_dout", 0, dout(0), 32'(wv[i]));
      cyc(0, 1, 2'b00, '0, 1, 2'b01);
    end
    chk("lit_drain_empty_n", 0, 32'(if_empty_n[0]), 0);

    cyc(0, 1, 2'b10, {8'hA5, 8'h00}, 1, 2'b10);
    chk("lit_rw_empty_count", 1, cnt(1), 1);
    chk("lit_rw_empty_dout", 1, dout(1), 32'h A5);
`ifdef KERNEL_CC_START_FIFO_ERR_EN
    chk("lit_err_udf", 1, 32'(err_underflow[1]), 1);
`endif

    cyc(0, 1, 2'b01, {8'h00, 8'h01}, 1, 2'b00);
    cyc(0, 1, 2'b01, {8'h00, 8'h02}, 1, 2'b00);
    for (int i = 0; i < 6; i++)
      cyc(0, 1, 2'b01, {8'h00, 8'(8'h10 + i)}, 1, 2'b01);
    chk("lit_rw_count", 0, cnt(0), 2);
    chk("lit_rw_dout", 0, dout(0), 32'h14);

    cyc(0, 0, 2'b11, {8'hEE, 8'hEE}, 1, 2'b00);
    cyc(0, 0, 2'b11, {8'hEE, 8'hEE}, 1, 2'b00);
    chk("lit_wce0_count", 0, cnt(0), 2);

    cyc(0, 1, 2'b11, {8'h77, 8'h66}, 1, 2'b00);
    cyc(1, 1, 2'b11, {8'h78, 8'h67}, 1, 2'b00);
    chk("lit_midrst_count", 0, cnt(0), 0);
    chk("lit_midrst_full_n", 0, 32'(if_full_n), 32'h3);
    chk("lit_midrst_empty_n", 0, 32'(if_empty_n), 32'h0);

    for (int n = 0; n < 4000; n++) begin
      logic rst;
      rst = ($urandom_range(0, 199) == 0);
      cyc(rst, ($urandom_range(0, 7) != 0), NC'($urandom),
          (NC*DW)'($urandom), ($urandom_range(0, 7) != 0), NC'($urandom));
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/kernel_cc_start_fifo_mc.md
KERNEL_CC_START_FIFO_MC -- requirements
Module: kernel_cc_start_fifo_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 1, bits per entry.
REQ-002 SHALL have parameter ADDR_WIDTH, default 2, address bits; DEPTH <= 2**ADDR_WIDTH.
REQ-003 SHALL have parameter DEPTH, default 4, entries per channel, range 2..2**ADDR_WIDTH.
REQ-004 SHALL have parameter NUM_CH, default 2, independent channels, range 1..16.
REQ-005 SHALL have parameter AF_THRESH, default DEPTH-1, almost-full level, range 1..DEPTH.
REQ-006 SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-007 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port if_write_ce  in  1  global write clock-enable, shared by all channels.
REQ-009 SHALL have port if_write  in  NUM_CH  per-channel write request.
REQ-010 SHALL have port if_din  in  NUM_CH*DATA_WIDTH  write data; channel c at bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port if_full_n  out  NUM_CH  channel not full.
REQ-012 SHALL have port if_almost_full_n  out  NUM_CH  channel count < AF_THRESH.
REQ-013 SHALL have port if_read_ce  in  1  global read clock-enable.
REQ-014 SHALL have port if_read  in  NUM_CH  per-channel read request.
REQ-015 SHALL have port if_empty_n  out  NUM_CH  channel not empty.
REQ-016 SHALL have port if_dout  out  NUM_CH*DATA_WIDTH  head-of-queue data, same slicing as if_din.
REQ-017 SHALL have port if_count  out  NUM_CH*(ADDR_WIDTH+1)  per-channel occupancy 0..DEPTH.
REQ-018 SHALL have ports err_overflow, err_underflow  out  NUM_CH each  sticky error flags (REQ-033).

Function
REQ-019 Each channel SHALL be an independent shift-register FIFO; channels share only clk, reset, if_write_ce, if_read_ce.
REQ-020 Write accept wa[c] SHALL be if_write[c] & if_write_ce & if_full_n[c]; read accept ra[c] SHALL be if_read[c] & if_read_ce & if_empty_n[c].
REQ-021 On wa[c], storage SHALL shift by one and if_din slice SHALL enter position 0; storage SHALL be unchanged otherwise.
REQ-022 if_dout slice SHALL be combinational: storage[count-1] when count>0, storage[0] when count=0 (first-word-fall-through, zero read latency).
REQ-023 count SHALL +1 on wa only, -1 on ra only, hold on both or neither.
REQ-024 Simultaneous read and write when empty: read not accepted, count 0->1, if_empty_n rises next cycle.
REQ-025 Simultaneous read and write when full: write not accepted, count DEPTH->DEPTH-1, if_full_n rises next cycle.
REQ-026 if_empty_n, if_full_n, if_almost_full_n SHALL be registered, equal to (count!=0), (count!=DEPTH), (count<AF_THRESH) of the current count, one-cycle update after the accepting edge.
REQ-027 Data written SHALL become visible at if_dout and if_empty_n exactly one cycle after the write edge.
REQ-028 Requests with the corresponding ce low SHALL have no effect on any state.

Reset
REQ-029 On reset: count=0, if_empty_n=0, if_full_n=1, if_almost_full_n=1, err flags=0, for all channels.
REQ-030 Reset SHALL override concurrent read/write in the same cycle; storage contents SHALL NOT be cleared.
REQ-031 Registers SHALL power up to reset values via initialisers.
REQ-032 if_dout after reset SHALL be don't-care until first write.

Configuration
REQ-033 With KERNEL_CC_START_FIFO_ERR_EN defined: err_overflow[c] SHALL set on if_write[c]&if_write_ce while if_full_n[c]=0, err_underflow[c] on if_read[c]&if_read_ce while if_empty_n[c]=0; both cleared only by reset.
REQ-034 Without KERNEL_CC_START_FIFO_ERR_EN: err ports SHALL exist and be tied to 0, no error logic synthesised.

Verification (DEPTH=4, NUM_CH=2, DATA_WIDTH=8, AF_THRESH=3, ce=1)
REQ-035 Reset, then write 0x11,0x22,0x33,0x44 on ch0 -> if_count ch0 1,2,3,4; if_almost_full_n[0]=0 after 3rd; if_full_n[0]=0 after 4th; ch1 empty_n=0 throughout.
REQ-036 Fifth write 0x55 to full ch0 -> rejected, count 4; then read four -> dout 0x11,0x22,0x33,0x44, if_empty_n[0]=0 after last; with ERR_EN err_overflow[0]=1.
REQ-037 Empty ch1, read+write 0xA5 same cycle -> count 1, dout 0xA5 next cycle; with ERR_EN err_underflow[1]=1.
REQ-038 ch0 at count 2, read+write each cycle for 6 cycles -> count stays 2, output order preserved, flags unchanged.
REQ-039 Writes on ch0 with if_write_ce=0 -> no state change; reset asserted mid-burst with write high -> next cycle count=0, empty_n=0, full_n=1, err=0.
